// File: rtl/fifo_pkg.sv
// Shared FIFO definitions: default geometry and Gray/binary pointer conversions.
package fifo_pkg;

  localparam int unsigned ADDRSIZE_DEF = 4;
  localparam int unsigned DATASIZE_DEF = 8;

  function automatic logic [31:0] bin2gray(input logic [31:0] b);
    return b ^ (b >> 1);
  endfunction

  // Bit i is the XOR of all Gray bits at or above i; upper unused bits must be zero.
  function automatic logic [31:0] gray2bin(input logic [31:0] g);
    logic [31:0] b;
    b[31] = g[31];
    for (int i = 30; i >= 0; i--) begin
      b[i] = b[i+1] ^ g[i];
    end
    return b;
  endfunction

endpackage

// File: rtl/fwft_out_reg.sv
// First-word-fall-through output register: pulls a word from memory whenever
// the register is free or being drained, and memory is non-empty.
module fwft_out_reg
  import fifo_pkg::*;
#(
  parameter int unsigned DATASIZE = DATASIZE_DEF
) (
  input  logic                rclk,
  input  logic                rrst,
  input  logic                rempty,
  input  logic [DATASIZE-1:0] rdata,
  input  logic                dout_ready,
  output logic                load,
  output logic [DATASIZE-1:0] dout,
  output logic                dout_valid
);

  assign load = ~rempty & (~dout_valid | dout_ready);

  always_ff @(posedge rclk or posedge rrst) begin
    if (rrst) begin
      dout       <= '0;
      dout_valid <= 1'b0;
    end else if (load) begin
      dout       <= rdata;
      dout_valid <= 1'b1;
    end else if (dout_ready) begin
      dout_valid <= 1'b0;
    end
  end

endmodule

// File: rtl/rptr_empty_fwft.sv
// Read-side pointer, empty/almost-empty flags and level for an async FIFO,
// with a first-word-fall-through output stage.
module rptr_empty_fwft
  import fifo_pkg::*;
#(
  parameter int unsigned ADDRSIZE      = ADDRSIZE_DEF,
  parameter int unsigned DATASIZE      = DATASIZE_DEF,
  parameter int unsigned AEMPTY_THRESH = 2
) (
  input  logic                rclk,
  input  logic                rrst,
  input  logic [ADDRSIZE:0]   rq2_wptr,
  input  logic [DATASIZE-1:0] rdata,
  output logic [ADDRSIZE-1:0] raddr,
  output logic [ADDRSIZE:0]   rptr,
  output logic                rempty,
  output logic                raempty,
  output logic [ADDRSIZE:0]   rlevel,
  output logic [DATASIZE-1:0] dout,
  output logic                dout_valid,
  input  logic                dout_ready
);

  logic [ADDRSIZE:0] rbin;
  logic [ADDRSIZE:0] rbinnext;
  logic [ADDRSIZE:0] rgraynext;
  logic [ADDRSIZE:0] wbin_s;
  logic [ADDRSIZE:0] level_next;
  logic              load;

  assign raddr      = rbin[ADDRSIZE-1:0];
  assign rbinnext   = rbin + {{ADDRSIZE{1'b0}}, load};
  assign rgraynext  = (ADDRSIZE+1)'(bin2gray(32'(rbinnext)));
  assign wbin_s     = (ADDRSIZE+1)'(gray2bin(32'(rq2_wptr)));
  // Level is taken against the post-load pointer so it never counts the output register.
  assign level_next = wbin_s - rbinnext;

  always_ff @(posedge rclk or posedge rrst) begin
    if (rrst) begin
      rbin    <= '0;
      rptr    <= '0;
      rempty  <= 1'b1;
      raempty <= 1'b1;
      rlevel  <= '0;
    end else begin
      rbin    <= rbinnext;
      rptr    <= rgraynext;
      rempty  <= (rgraynext == rq2_wptr);
      raempty <= (32'(level_next) <= AEMPTY_THRESH);
      rlevel  <= level_next;
    end
  end

  fwft_out_reg #(
    .DATASIZE(DATASIZE)
  ) u_out_reg (
    .rclk      (rclk),
    .rrst      (rrst),
    .rempty    (rempty),
    .rdata     (rdata),
    .dout_ready(dout_ready),
    .load      (load),
    .dout      (dout),
    .dout_valid(dout_valid)
  );

endmodule

// File: tb/tb_rptr_empty_fwft.sv
// Directed bench for rptr_empty_fwft with a behavioural memory and write pointer.
module tb_rptr_empty_fwft;

  logic       rclk;
  logic       rrst;
  logic [4:0] rq2_wptr;
  logic [7:0] rdata;
  logic [3:0] raddr;
  logic [4:0] rptr;
  logic       rempty;
  logic       raempty;
  logic [4:0] rlevel;
  logic [7:0] dout;
  logic       dout_valid;
  logic       dout_ready;

  logic [7:0] mem [16];
  logic [4:0] wbin;
  int         n_total;
  int         n_fail;

  assign rq2_wptr = wbin ^ (wbin >> 1);
  assign rdata    = mem[raddr];

  rptr_empty_fwft #(
    .ADDRSIZE     (4),
    .DATASIZE     (8),
    .AEMPTY_THRESH(2)
  ) dut (
    .rclk      (rclk),
    .rrst      (rrst),
    .rq2_wptr  (rq2_wptr),
    .rdata     (rdata),
    .raddr     (raddr),
    .rptr      (rptr),
    .rempty    (rempty),
    .raempty   (raempty),
    .rlevel    (rlevel),
    .dout      (dout),
    .dout_valid(dout_valid),
    .dout_ready(dout_ready)
  );

  initial rclk = 1'b0;
  always #5 rclk = ~rclk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    assert (obs === exp)
    else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge rclk);
    #1;
  endtask

  task automatic do_reset();
    rrst = 1'b1;
    wbin = '0;
    dout_ready = 1'b0;
    tick();
    tick();
    rrst = 1'b0;
    tick();
  endtask

  initial begin
    n_total = 0;
    n_fail  = 0;
    for (int i = 0; i < 16; i++) mem[i] = 8'(i * 7 + 3);
    rrst = 1'b1;
    wbin = '0;
    dout_ready = 1'b0;
    tick();
    tick();

    // Reset state
    chk("rst_rempty", 32'(rempty), 32'h1);
    chk("rst_raempty", 32'(raempty), 32'h1);
    chk("rst_rlevel", 32'(rlevel), 32'h0);
    chk("rst_rptr", 32'(rptr), 32'h0);
    chk("rst_dout_valid", 32'(dout_valid), 32'h0);
    chk("rst_dout", 32'(dout), 32'h0);
    rrst = 1'b0;
    tick();
    chk("idle_rempty", 32'(rempty), 32'h1);

    // Single word
    mem[0] = 8'hA5;
    wbin = 5'd1;
    tick();
    chk("sw_e1_rempty", 32'(rempty), 32'h0);
    chk("sw_e1_dout_valid", 32'(dout_valid), 32'h0);
    chk("sw_e1_rlevel", 32'(rlevel), 32'h1);
    tick();
    chk("sw_e2_dout_valid", 32'(dout_valid), 32'h1);
    chk("sw_e2_dout", 32'(dout), 32'hA5);
    chk("sw_e2_raddr", 32'(raddr), 32'h1);
    chk("sw_e2_rptr", 32'(rptr), 32'h1);
    chk("sw_e2_rlevel", 32'(rlevel), 32'h0);
    tick();
    chk("sw_e3_rempty", 32'(rempty), 32'h1);
    chk("sw_e3_dout_hold", 32'(dout), 32'hA5);
    chk("sw_e3_raddr_hold", 32'(raddr), 32'h1);
    dout_ready = 1'b1;
    tick();
    chk("sw_drain_valid", 32'(dout_valid), 32'h0);
    chk("sw_drain_raddr", 32'(raddr), 32'h1);

    // Backpressure
    do_reset();
    mem[0] = 8'h11;
    mem[1] = 8'h22;
    mem[2] = 8'h33;
    wbin = 5'd3;
    tick();
    tick();
    chk("bp_first", 32'(dout), 32'h11);
    for (int i = 0; i < 5; i++) begin
      tick();
      chk("bp_hold_dout", 32'(dout), 32'h11);
    end
    chk("bp_hold_valid", 32'(dout_valid), 32'h1);
    chk("bp_raddr", 32'(raddr), 32'h1);
    chk("bp_rlevel", 32'(rlevel), 32'h2);
    dout_ready = 1'b1;
    tick();
    chk("bp_second", 32'(dout), 32'h22);
    tick();
    chk("bp_third", 32'(dout), 32'h33);
    chk("bp_third_valid", 32'(dout_valid), 32'h1);
    tick();
    chk("bp_end_valid", 32'(dout_valid), 32'h0);
    chk("bp_end_rempty", 32'(rempty), 32'h1);

    // Wrap
    do_reset();
    dout_ready = 1'b1;
    wbin = 5'd15;
    for (int i = 0; i < 20; i++) tick();
    chk("wr_pre_raddr", 32'(raddr), 32'hF);
    chk("wr_pre_rptr", 32'(rptr), 32'h08);
    chk("wr_pre_valid", 32'(dout_valid), 32'h0);
    dout_ready = 1'b0;
    mem[15] = 8'h5A;
    wbin = 5'd16;
    tick();
    chk("wr_e1_rempty", 32'(rempty), 32'h0);
    tick();
    chk("wr_rptr", 32'(rptr), 32'h18);
    chk("wr_raddr", 32'(raddr), 32'h0);
    chk("wr_dout", 32'(dout), 32'h5A);

    // Full depth and almost-empty boundary
    do_reset();
    wbin = 5'd16;
    tick();
    chk("fd_rlevel", 32'(rlevel), 32'd16);
    chk("fd_raempty", 32'(raempty), 32'h0);
    tick();
    chk("fd_rlevel_after_load", 32'(rlevel), 32'd15);
    dout_ready = 1'b1;
    for (int i = 0; i < 12; i++) tick();
    chk("fd_lvl3", 32'(rlevel), 32'd3);
    chk("fd_lvl3_raempty", 32'(raempty), 32'h0);
    tick();
    chk("fd_lvl2", 32'(rlevel), 32'd2);
    chk("fd_lvl2_raempty", 32'(raempty), 32'h1);

    // Reset asserted between edges mid-transfer
    do_reset();
    wbin = 5'd6;
    tick();
    tick();
    chk("mr_pre_rlevel", 32'(rlevel), 32'd5);
    chk("mr_pre_valid", 32'(dout_valid), 32'h1);
    #2;
    rrst = 1'b1;
    #1;
    chk("mr_rempty", 32'(rempty), 32'h1);
    chk("mr_raempty", 32'(raempty), 32'h1);
    chk("mr_rlevel", 32'(rlevel), 32'h0);
    chk("mr_rptr", 32'(rptr), 32'h0);
    chk("mr_raddr", 32'(raddr), 32'h0);
    chk("mr_valid", 32'(dout_valid), 32'h0);
    chk("mr_dout", 32'(dout), 32'h0);
    tick();
    chk("mr_held_valid", 32'(dout_valid), 32'h0);
    chk("mr_held_rlevel", 32'(rlevel), 32'h0);

    $display("%0d/%0d checks passed", n_total - n_fail, n_total);
    $finish;
  end

endmodule
